acc_instr_sequencer: RTL
========================

Name: acc_instr_sequencer

Overview:
Multicycle control unit for the accumulator processor. It sequences the fetch, stage-load, decode, operand-address, memory and execute phases, and drives every datapath control strobe: instruction RAM, PC, stage register, data RAM, indirect-address register, ACC, shifter and ALU. It replaces the fetch-only control loop, sits beside the datapath, and takes opcode and address mode from the stage register outputs.

Parameters:
OPW, 5, opcode width (stage register instruction field)
MODEW, 3, address-mode width
ALUW, 2, ALU operation select width

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; forces state to FETCH and all outputs low
run  in  1  allows a new fetch; sampled only in FETCH
instr_op  in  OPW  opcode from stage register
addr_mode  in  MODEW  address mode from stage register
acc_zero  in  1  ACC == 0 flag
acc_neg  in  1  ACC MSB flag
instr_ram_en, instr_ram_rd, pc_inc, pc_load  out  1 each  instruction-side strobes
stage_ld  out  1  stage register load
dram_en, dram_rd, dram_addr_sel, ind_addr_ld  out  1 each  data-side strobes; dram_rd=0 with dram_en=1 is a write; addr_sel 0=operand field, 1=indirect register
acc_ld, acc_in_sel, shift_en, shift_dir, alu_in_sel  out  1 each  acc_in_sel 1=data RAM, 0=ALU/shifter; shift_dir 0=left, 1=right; alu_in_sel 1=immediate, 0=data RAM
alu_op  out  ALUW  00 add, 01 sub, 10 and, 11 or
instr_done  out  1  one-cycle pulse in the last cycle of each instruction
illegal  out  1  one-cycle pulse in DECODE for an undefined opcode or mode
halted  out  1  high while in HALT

Behaviour:
- Opcodes: NOP 00000, LDA 00001, STA 00010, ADD 00011, SUB 00100, AND 00101, OR 00110, SHL 00111, SHR 01000, JMP 01001, JZ 01010, JN 01011, HLT 11111. All others are illegal.
- Modes: 000 immediate, 001 direct, 010 indirect. Others are illegal. Mode is ignored for NOP, SHL, SHR, JMP, JZ, JN and HLT.
- Moore outputs decode from registered state plus opcode/mode registers latched in DECODE. Outputs not listed for a state are 0.
- Reset: all outputs 0 asynchronously; state = FETCH; opcode/mode registers = 0. Reset is legal mid-instruction: a partly executed instruction is abandoned with no further strobes.
- FETCH:
  - If run=0: stay, all outputs 0.
  - If run=1: instr_ram_en=instr_ram_rd=pc_inc=1, then go to STAGE.
- STAGE: stage_ld=1, then go to DECODE.
- DECODE: latch instr_op/addr_mode.
  - HLT -> HALT.
  - Illegal opcode, illegal mode on a mode-using op, or NOP -> FETCH, with instr_done=1 (and illegal=1 if illegal).
  - STA immediate is illegal.
  - Jumps, shifts and immediate-mode ops -> EXEC.
  - Direct -> MEM.
  - Indirect -> IND.
- IND: dram_en=dram_rd=ind_addr_ld=1, dram_addr_sel=0, then go to MEM.
- MEM: dram_en=1; dram_addr_sel=1 if indirect; dram_rd=0 for STA, else 1.
  - STA: instr_done=1 -> FETCH.
  - Otherwise -> EXEC.
- EXEC: instr_done=1, then go to FETCH.
  - LDA: acc_ld=1, acc_in_sel=1.
  - ADD/SUB/AND/OR: acc_ld=1, acc_in_sel=0, alu_op per opcode, alu_in_sel=1 iff immediate.
  - SHL/SHR: acc_ld=1, shift_en=1, shift_dir per opcode.
  - JMP: pc_load=1.
  - JZ: pc_load=acc_zero.
  - JN: pc_load=acc_neg. Flags are sampled in EXEC.
- HALT: halted=1 and all other outputs 0. Exit only via reset; run is ignored.
- Latency (cycles, FETCH to instr_done inclusive):
  - NOP/illegal: 3
  - immediate/shift/jump: 4
  - direct ALU/LDA: 5
  - indirect ALU/LDA: 6
  - STA direct: 4
  - STA indirect: 5
- Back-to-back: FETCH follows instr_done with no bubble when run=1.

Decomposition:
- Package acc_ctrl_pkg holds:
  - opcode constants
  - mode constants
  - alu_op encodings
  - state encoding: FETCH, STAGE, DECODE, IND, MEM, EXEC, HALT (3-bit)
- One natural sub-module, acc_ctrl_decode: combinational op/mode -> next-phase class, legality, alu_op and shift_dir. Leave the FSM and output decode in acc_instr_sequencer.

Test Plan:
- Reset mid-MEM, then release with run=1, op=ADD (00011), mode=001 → all outputs 0 during reset. Then FETCH, STAGE, DECODE, MEM (dram_en=1, dram_rd=1), EXEC (acc_ld=1, alu_op=00, alu_in_sel=0), with instr_done in cycle 5.
- LDA indirect (00001/010) → IND asserts ind_addr_ld=1 with dram_addr_sel=0. MEM asserts dram_addr_sel=1, dram_rd=1. EXEC asserts acc_ld=1, acc_in_sel=1. instr_done in cycle 6.
- STA direct (00010/001) → MEM asserts dram_en=1, dram_rd=0 and instr_done=1. No acc_ld at any point. Next cycle is FETCH.
- JZ with acc_zero=0, then again with acc_zero=1; and JN with acc_neg=1 → pc_load=0, 1 and 1 respectively in EXEC. Each takes 4 cycles.
- Opcode 01111, then STA immediate (00010/000) → illegal=1 and instr_done=1 in DECODE. No datapath strobes; returns to FETCH.
- HLT (11111) with run held 1 → halted=1 from the cycle after DECODE; no fetch for 10 cycles. Reset returns to FETCH; run=0 holds FETCH with instr_ram_en=0.

Source files
------------

// File: rtl/acc_ctrl_pkg.sv
// Shared encodings for the accumulator processor control unit: opcodes,
// address modes, ALU selects, sequencer states and decode phase classes.
package acc_ctrl_pkg;

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_LDA = 5'b00001;
    localparam logic [4:0] OP_STA = 5'b00010;
    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_SHL = 5'b00111;
    localparam logic [4:0] OP_SHR = 5'b01000;
    localparam logic [4:0] OP_JMP = 5'b01001;
    localparam logic [4:0] OP_JZ  = 5'b01010;
    localparam logic [4:0] OP_JN  = 5'b01011;
    localparam logic [4:0] OP_HLT = 5'b11111;

    localparam logic [2:0] MODE_IMM = 3'b000;
    localparam logic [2:0] MODE_DIR = 3'b001;
    localparam logic [2:0] MODE_IND = 3'b010;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Sequencer phases
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        STAGE  = 3'd1,
        DECODE = 3'd2,
        IND    = 3'd3,
        MEM    = 3'd4,
        EXEC   = 3'd5,
        HALT   = 3'd6
    } seqState_t;

    // Where DECODE sends an instruction next (PH_FETCH = finishes in DECODE)
    typedef enum logic [2:0] {
        PH_FETCH = 3'd0,
        PH_EXEC  = 3'd1,
        PH_MEM   = 3'd2,
        PH_IND   = 3'd3,
        PH_HALT  = 3'd4
    } phase_t;

    // True for the two-operand ALU instructions
    function automatic logic isAluOp(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/acc_ctrl_decode.sv
// Combinational instruction classifier: opcode/mode -> next phase, legality,
// ALU operation and shift direction.
module acc_ctrl_decode
    import acc_ctrl_pkg::*;
#(
    parameter int OPW   = 5,
    parameter int MODEW = 3,
    parameter int ALUW  = 2
) (
    input  logic [OPW-1:0]   op,
    input  logic [MODEW-1:0] mode,
    output phase_t           nextPhase,
    output logic             isIllegal,
    output logic [ALUW-1:0]  aluOp,
    output logic             shiftDir
);

    // Phase class for memory-using ops follows the address mode
    phase_t modePhase;
    logic   modeBad;

    // Map the address mode to the operand-fetch path
    always_comb begin
        modePhase = PH_FETCH;
        modeBad   = 1'b0;
        case (mode)
            MODE_IMM: modePhase = PH_EXEC;
            MODE_DIR: modePhase = PH_MEM;
            MODE_IND: modePhase = PH_IND;
            default:  modeBad   = 1'b1;
        endcase
    end

    // Classify the opcode; mode only matters for LDA/STA and the ALU ops
    always_comb begin
        nextPhase = PH_FETCH;
        isIllegal = 1'b0;
        aluOp     = ALU_ADD;
        shiftDir  = 1'b0;
        case (op)
            OP_NOP: nextPhase = PH_FETCH;
            OP_HLT: nextPhase = PH_HALT;
            OP_SHL: nextPhase = PH_EXEC;
            OP_SHR: begin
                nextPhase = PH_EXEC;
                shiftDir  = 1'b1;
            end
            OP_JMP, OP_JZ, OP_JN: nextPhase = PH_EXEC;
            OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                if (modeBad) begin
                    isIllegal = 1'b1;
                end else begin
                    nextPhase = modePhase;
                end
                case (op)
                    OP_SUB:  aluOp = ALU_SUB;
                    OP_AND:  aluOp = ALU_AND;
                    OP_OR:   aluOp = ALU_OR;
                    default: aluOp = ALU_ADD;
                endcase
            end
            OP_STA: begin
                // A store needs an address, so immediate mode is meaningless
                if (modeBad || (mode == MODE_IMM)) begin
                    isIllegal = 1'b1;
                end else begin
                    nextPhase = modePhase;
                end
            end
            default: isIllegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/acc_instr_sequencer.sv
// Multicycle control unit for the accumulator processor: walks each
// instruction through FETCH/STAGE/DECODE/IND/MEM/EXEC and drives every
// datapath strobe from the current phase and the latched opcode/mode.
module acc_instr_sequencer
    import acc_ctrl_pkg::*;
#(
    parameter int OPW   = 5,
    parameter int MODEW = 3,
    parameter int ALUW  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [OPW-1:0]   instr_op,
    input  logic [MODEW-1:0] addr_mode,
    input  logic             acc_zero,
    input  logic             acc_neg,
    output logic             instr_ram_en,
    output logic             instr_ram_rd,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             stage_ld,
    output logic             dram_en,
    output logic             dram_rd,
    output logic             dram_addr_sel,
    output logic             ind_addr_ld,
    output logic             acc_ld,
    output logic             acc_in_sel,
    output logic             shift_en,
    output logic             shift_dir,
    output logic             alu_in_sel,
    output logic [ALUW-1:0]  alu_op,
    output logic             instr_done,
    output logic             illegal,
    output logic             halted
);

    seqState_t        stateReg;
    logic [OPW-1:0]   opReg;
    logic [MODEW-1:0] modeReg;

    // In DECODE the stage register is classified live; afterwards the latched copy is used
    logic [OPW-1:0]   decOp;
    logic [MODEW-1:0] decMode;
    phase_t           decPhase;
    logic             decIllegal;
    logic [ALUW-1:0]  decAluOp;
    logic             decShiftDir;

    assign decOp   = (stateReg == DECODE) ? instr_op  : opReg;
    assign decMode = (stateReg == DECODE) ? addr_mode : modeReg;

    acc_ctrl_decode #(
        .OPW   (OPW),
        .MODEW (MODEW),
        .ALUW  (ALUW)
    ) decodeInst (
        .op        (decOp),
        .mode      (decMode),
        .nextPhase (decPhase),
        .isIllegal (decIllegal),
        .aluOp     (decAluOp),
        .shiftDir  (decShiftDir)
    );

    // Phase sequencing and opcode/mode capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= FETCH;
            opReg    <= '0;
            modeReg  <= '0;
        end else begin
            case (stateReg)
                FETCH:  if (run) stateReg <= STAGE;
                STAGE:  stateReg <= DECODE;
                DECODE: begin
                    opReg   <= instr_op;
                    modeReg <= addr_mode;
                    case (decPhase)
                        PH_HALT: stateReg <= HALT;
                        PH_EXEC: stateReg <= EXEC;
                        PH_MEM:  stateReg <= MEM;
                        PH_IND:  stateReg <= IND;
                        default: stateReg <= FETCH;
                    endcase
                end
                IND:    stateReg <= MEM;
                MEM:    stateReg <= (opReg == OP_STA) ? FETCH : EXEC;
                EXEC:   stateReg <= FETCH;
                HALT:   stateReg <= HALT;
                default: stateReg <= FETCH;
            endcase
        end
    end

    // Strobe decode per phase; reset forces every strobe low immediately
    always_comb begin
        instr_ram_en  = 1'b0;
        instr_ram_rd  = 1'b0;
        pc_inc        = 1'b0;
        pc_load       = 1'b0;
        stage_ld      = 1'b0;
        dram_en       = 1'b0;
        dram_rd       = 1'b0;
        dram_addr_sel = 1'b0;
        ind_addr_ld   = 1'b0;
        acc_ld        = 1'b0;
        acc_in_sel    = 1'b0;
        shift_en      = 1'b0;
        shift_dir     = 1'b0;
        alu_in_sel    = 1'b0;
        alu_op        = '0;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        halted        = 1'b0;
        if (!reset) begin
            case (stateReg)
                FETCH: begin
                    instr_ram_en = run;
                    instr_ram_rd = run;
                    pc_inc       = run;
                end
                STAGE: stage_ld = 1'b1;
                DECODE: begin
                    // NOP and illegal encodings complete here
                    instr_done = (decPhase == PH_FETCH);
                    illegal    = decIllegal;
                end
                IND: begin
                    dram_en     = 1'b1;
                    dram_rd     = 1'b1;
                    ind_addr_ld = 1'b1;
                end
                MEM: begin
                    dram_en       = 1'b1;
                    dram_addr_sel = (modeReg == MODE_IND);
                    dram_rd       = (opReg != OP_STA);
                    instr_done    = (opReg == OP_STA);
                end
                EXEC: begin
                    instr_done = 1'b1;
                    if (opReg == OP_LDA) begin
                        acc_ld     = 1'b1;
                        acc_in_sel = 1'b1;
                    end else if (isAluOp(opReg)) begin
                        acc_ld     = 1'b1;
                        alu_op     = decAluOp;
                        alu_in_sel = (modeReg == MODE_IMM);
                    end else if ((opReg == OP_SHL) || (opReg == OP_SHR)) begin
                        acc_ld    = 1'b1;
                        shift_en  = 1'b1;
                        shift_dir = decShiftDir;
                    end else if (opReg == OP_JMP) begin
                        pc_load = 1'b1;
                    end else if (opReg == OP_JZ) begin
                        pc_load = acc_zero;
                    end else if (opReg == OP_JN) begin
                        pc_load = acc_neg;
                    end
                end
                HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
